pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder.sv | 120 ++++++++++++
 tb/tb_pipe_adder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// Carry-chopped pipelined adder/subtractor: each stage adds one CHUNK-bit slice and hands
// its carry, finished low sum bits and untouched high operand bits to the next register.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CHUNK = WIDTH / STAGES;

    // Stage registers: index k holds the state after slice k has been added
    logic [WIDTH-1:0] opa_p   [STAGES];
    logic [WIDTH-1:0] opb_p   [STAGES];
    logic [WIDTH-1:0] sum_p   [STAGES];
    logic             carry_p [STAGES];
    logic             vld_p   [STAGES];
    logic             ovf_p;

    // Inputs seen by each stage's slice adder
    logic [WIDTH-1:0] src_a [STAGES];
    logic [WIDTH-1:0] src_b [STAGES];
    logic [WIDTH-1:0] src_s [STAGES];
    logic             src_c [STAGES];
    logic             src_v [STAGES];

    logic [WIDTH-1:0] sum_d   [STAGES];
    logic             carry_d [STAGES];
    logic             ovf_d;
    logic             stall;

    function automatic logic [CHUNK:0] slice_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             c);
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
    endfunction

    // Signed overflow: operands agree in sign but the result does not
    function automatic logic signed_ovf(input logic msb_a, input logic msb_b,
                                        input logic msb_s);
        return (msb_a == msb_b) && (msb_s != msb_a);
    endfunction

    assign stall    = vld_p[STAGES-1] && !out_ready;
    assign in_ready = !stall;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_src
        if (k == 0) begin : g_in
            // Subtraction folds into addition of the inverted operand plus an inverted carry
            assign src_a[k] = a;
            assign src_b[k] = b ^ {WIDTH{sub}};
            assign src_s[k] = '0;
            assign src_c[k] = cin ^ sub;
            assign src_v[k] = in_valid;
        end else begin : g_chain
            assign src_a[k] = opa_p[k-1];
            assign src_b[k] = opb_p[k-1];
            assign src_s[k] = sum_p[k-1];
            assign src_c[k] = carry_p[k-1];
            assign src_v[k] = vld_p[k-1];
        end
    end

    always_comb begin
        logic [CHUNK:0] part;
        part  = '0;
        ovf_d = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            part       = slice_add(src_a[i][i*CHUNK +: CHUNK], src_b[i][i*CHUNK +: CHUNK],
                                   src_c[i]);
            sum_d[i]   = src_s[i];
            sum_d[i][i*CHUNK +: CHUNK] = part[CHUNK-1:0];
            carry_d[i] = part[CHUNK];
        end
        ovf_d = signed_ovf(src_a[STAGES-1][WIDTH-1], src_b[STAGES-1][WIDTH-1],
                           sum_d[STAGES-1][WIDTH-1]);
    end

    // Pipeline register boundary: whole pipe advances together or holds on a stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                opa_p[i]   <= '0;
                opb_p[i]   <= '0;
                sum_p[i]   <= '0;
                carry_p[i] <= 1'b0;
                vld_p[i]   <= 1'b0;
            end
            ovf_p <= 1'b0;
        end else if (!stall) begin
            for (int i = 0; i < STAGES; i++) begin
                opa_p[i]   <= src_a[i];
                opb_p[i]   <= src_b[i];
                sum_p[i]   <= sum_d[i];
                carry_p[i] <= carry_d[i];
                vld_p[i]   <= src_v[i];
            end
            ovf_p <= ovf_d;
        end
    end

    assign sum       = sum_p[STAGES-1];
    assign cout      = carry_p[STAGES-1];
    assign ovf       = ovf_p;
    assign out_valid = vld_p[STAGES-1];

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: 32-bit/4-stage instance against an arithmetic reference model,
// plus an 8-bit single-stage instance with directed vectors.
module tb_pipe_adder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] a, b, sum;
    logic        cin, sub, in_valid, in_ready, cout, ovf, out_valid, out_ready;

    logic [7:0]  a8, b8, sum8;
    logic        cin8, sub8, in_valid8, in_ready8, cout8, ovf8, out_valid8, out_ready8;

    int          checks = 0;
    int          passed = 0;
    int          pops   = 0;
    logic [33:0] q[$];
    logic        prev_stall = 1'b0;
    logic [33:0] prev_out   = '0;

    pipe_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .sub(sub),
        .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .cout(cout),
        .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
    );

    pipe_adder #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .in_valid(in_valid8), .in_ready(in_ready8), .sum(sum8), .cout(cout8),
        .ovf(ovf8), .out_valid(out_valid8), .out_ready(out_ready8)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    // Reference: plain integer arithmetic, returns {ovf, cout, sum}
    function automatic logic [33:0] model(input int w, input longint x, input longint y,
                                          input bit c, input bit s);
        longint m, ci, sx, sy, u, sr;
        logic [63:0] uu;
        m  = longint'(1) <<< w;
        ci = c ? longint'(1) : longint'(0);
        sx = (x >= m / 2) ? x - m : x;
        sy = (y >= m / 2) ? y - m : y;
        if (s) begin
            u  = m + x - y - ci;
            sr = sx - sy - ci;
        end else begin
            u  = x + y + ci;
            sr = sx + sy + ci;
        end
        uu = 64'(u);
        return {(sr >= m / 2) || (sr < -(m / 2)), uu[w], 32'(u & (m - 1))};
    endfunction

    always @(posedge rst) q.delete();

    // Compare process: every cycle, sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'(1));
                chk("stall_hold", 64'({ovf, cout, sum}), 64'(prev_out));
            end
            if (out_valid) begin
                chk("out_expected", 64'(q.size() != 0), 64'(1));
                if (q.size() != 0) begin
                    chk("result", 64'({ovf, cout, sum}), 64'(q[0]));
                    if (out_ready) begin
                        void'(q.pop_front());
                        pops++;
                    end
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(32, longint'(a), longint'(b), cin, sub));
            prev_stall = out_valid && !out_ready;
            prev_out   = {ovf, cout, sum};
        end
    end

    task automatic send_one(input logic [31:0] ta, input logic [31:0] tbv, input logic tc,
                            input logic ts, input logic [31:0] es, input logic ec,
                            input logic eo, input string nm);
        int n;
        a = ta; b = tbv; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({nm, "_in_ready"}, 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 12);
        chk({nm, "_latency"}, 64'(n), 64'(4));
        chk({nm, "_sum"}, 64'(sum), 64'(es));
        chk({nm, "_cout"}, 64'(cout), 64'(ec));
        chk({nm, "_ovf"}, 64'(ovf), 64'(eo));
        @(posedge clk); #1;
    endtask

    task automatic burst();
        logic [7:0] pat;
        int i, cyc, p0;
        pat = 8'b1110_1001;  // out_ready 1,0,0,1,0,1,1,1 from bit 0 upward
        i = 0; cyc = 0; p0 = pops;
        while ((i < 8 || pops - p0 < 8) && cyc < 100) begin
            out_ready = pat[cyc % 8];
            if (i < 8) begin
                a   = 32'(32'h1111_1111 * (i + 1));
                b   = 32'(32'h0F0F_0F0F + i * 32'h0100_0001);
                sub = i[0];
                cin = i[1];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) i++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("burst_accepted", 64'(i), 64'(8));
        chk("burst_results", 64'(pops - p0), 64'(8));
        chk("burst_queue_empty", 64'(q.size()), 64'(0));
    endtask

    task automatic reset_test();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int j = 0; j < 4; j++) begin
            a = 32'(32'h1000 * (j + 1)); b = 32'(j); cin = 1'b0; sub = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("rst_pre_valid", 64'(out_valid), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("rst_async_valid", 64'(out_valid), 64'(0));
        chk("rst_async_sum", 64'(sum), 64'(0));
        chk("rst_async_cout", 64'(cout), 64'(0));
        chk("rst_async_ovf", 64'(ovf), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #3;
        rst = 1'b0;
        send_one(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0,
                 "post_rst");
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(out_valid), 64'(0));
        end
    endtask

    task automatic send8(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                         input logic ts, input logic [7:0] es, input logic ec,
                         input logic eo, input string nm);
        logic [33:0] m;
        a8 = ta; b8 = tbv; cin8 = tc; sub8 = ts; in_valid8 = 1'b1;
        #1;
        chk({nm, "_pre_valid"}, 64'(out_valid8), 64'(0));
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(negedge clk);
        m = model(8, longint'(ta), longint'(tbv), tc, ts);
        chk({nm, "_valid"}, 64'(out_valid8), 64'(1));
        chk({nm, "_model"}, 64'({ovf8, cout8, sum8}), 64'({m[33], m[32], m[7:0]}));
        chk({nm, "_sum"}, 64'(sum8), 64'(es));
        chk({nm, "_cout"}, 64'(cout8), 64'(ec));
        chk({nm, "_ovf"}, 64'(ovf8), 64'(eo));
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1;
        #1;
        chk("reset_valid", 64'(out_valid), 64'(0));
        chk("reset_sum", 64'(sum), 64'(0));
        chk("reset_cout", 64'(cout), 64'(0));
        chk("reset_ovf", 64'(ovf), 64'(0));
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset8_valid", 64'(out_valid8), 64'(0));
        chk("reset8_sum", 64'(sum8), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        send_one(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "wrap");
        send_one(32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_neg");
        send_one(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "pos_ovf");
        send_one(32'h0000_00FF, 32'h1, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "chunk_carry");
        send_one(32'h00FF_FFFF, 32'h1, 1'b1, 1'b0, 32'h0100_0001, 1'b0, 1'b0, "carry_cin");
        send_one(32'd10, 32'd3, 1'b1, 1'b1, 32'd6, 1'b1, 1'b0, "sub_borrow_in");
        send_one(32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "neg_ovf");
        send_one(32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, "zero_sub");

        burst();
        reset_test();

        send8(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "w8_min_add");
        send8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "w8_pos_ovf");
        send8(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, "w8_sub_neg");
        send8(8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, "w8_sub_pos");
        send8(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "w8_cin_wrap");

        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("final_drain", 64'(q.size()), 64'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
